// File: rtl/binary_sema_master.sv
`default_nettype none
// ============================================================================
// Module      : binary_sema_master
// Description : Bus master that acquires/releases binary semaphores through a
//               write-then-readback handshake, with bounded retry and backoff.
//               Optional macro SEMA_UNLOCK_VERIFY_EN adds a readback after unlock.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_sema_master #(
    parameter int MAX_RETRY = 15,
    parameter int BACKOFF   = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        op_i,
    input  logic [9:0]  sem_i,
    input  logic [23:0] key_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ok_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [13:0] adr_o,
    output logic [31:0] dat_o,
    input  logic        ack_i,
    input  logic [31:0] dat_i
);

    localparam int c_rty_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int c_bo_w  = (BACKOFF > 1)   ? $clog2(BACKOFF)       : 1;
    localparam int c_tmo_w = (TIMEOUT > 1)   ? $clog2(TIMEOUT)       : 1;

    localparam logic [c_rty_w-1:0] c_rty_max  = c_rty_w'(MAX_RETRY);
    localparam logic [c_bo_w-1:0]  c_bo_last  = c_bo_w'(BACKOFF - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
    localparam logic [1:0]         c_rgn_lock   = 2'b00;
    localparam logic [1:0]         c_rgn_unlock = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LWR     = 3'd1,
        S_LRD     = 3'd2,
        S_BACKOFF = 3'd3,
        S_UWR     = 3'd4,
        S_URD     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t               r_state, w_state;
    logic                 r_cyc,   w_cyc;
    logic                 r_we,    w_we;
    logic [13:0]          r_adr,   w_adr;
    logic [31:0]          r_dat,   w_dat;
    logic                 r_ok,    w_ok;
    logic [c_rty_w-1:0]   r_retry, w_retry;
    logic [c_bo_w-1:0]    r_bo,    w_bo;
    logic [c_tmo_w-1:0]   r_tmo,   w_tmo;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_ok    <= 1'b0;
            r_retry <= '0;
            r_bo    <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state;
            r_cyc   <= w_cyc;
            r_we    <= w_we;
            r_adr   <= w_adr;
            r_dat   <= w_dat;
            r_ok    <= w_ok;
            r_retry <= w_retry;
            r_bo    <= w_bo;
            r_tmo   <= w_tmo;
        end
    end

    // Reads are entered with the strobe low so every bus cycle is preceded by
    // at least one idle cycle; writes start with the strobe already set.
    always_comb begin
        w_state = r_state;
        w_cyc   = r_cyc;
        w_we    = r_we;
        w_adr   = r_adr;
        w_dat   = r_dat;
        w_ok    = r_ok;
        w_retry = r_retry;
        w_bo    = r_bo;
        w_tmo   = r_tmo;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    w_state = op_i ? S_UWR : S_LWR;
                    w_cyc   = 1'b1;
                    w_we    = 1'b1;
                    w_adr   = {(op_i ? c_rgn_unlock : c_rgn_lock), sem_i, 2'b00};
                    w_dat   = {8'h00, key_i};
                    w_retry = '0;
                    w_tmo   = '0;
                end
            end
            S_BACKOFF: begin
                if (r_bo == c_bo_last) begin
                    w_state = S_LWR;
                    w_cyc   = 1'b1;
                    w_we    = 1'b1;
                    w_tmo   = '0;
                    w_bo    = '0;
                end else begin
                    w_bo = r_bo + 1'b1;
                end
            end
            S_LWR, S_LRD, S_UWR, S_URD: begin
                if (!r_cyc) begin
                    w_cyc = 1'b1;
                    w_we  = 1'b0;
                    w_adr = {c_rgn_lock, r_adr[11:0]};
                    w_tmo = '0;
                end else if (ack_i) begin
                    w_cyc = 1'b0;
                    w_we  = 1'b0;
                    case (r_state)
                        S_LWR: w_state = S_LRD;
                        S_LRD: begin
                            if (dat_i == r_dat) begin
                                w_state = S_DONE;
                                w_ok    = 1'b1;
                            end else if (r_retry < c_rty_max) begin
                                w_state = S_BACKOFF;
                                w_retry = r_retry + 1'b1;
                                w_bo    = '0;
                            end else begin
                                w_state = S_DONE;
                                w_ok    = 1'b0;
                            end
                        end
                        S_UWR: begin
`ifdef SEMA_UNLOCK_VERIFY_EN
                            w_state = S_URD;
`else
                            w_state = S_DONE;
                            w_ok    = 1'b1;
`endif
                        end
                        default: begin
                            // Released means the lock word no longer carries our key.
                            w_state = S_DONE;
                            w_ok    = (dat_i[23:0] != r_dat[23:0]);
                        end
                    endcase
                end else if (r_tmo == c_tmo_last) begin
                    w_cyc   = 1'b0;
                    w_we    = 1'b0;
                    w_ok    = 1'b0;
                    w_state = S_DONE;
                end else begin
                    w_tmo = r_tmo + 1'b1;
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    assign cyc_o  = r_cyc;
    assign stb_o  = r_cyc;
    assign we_o   = r_we;
    assign adr_o  = r_adr;
    assign dat_o  = r_dat;
    assign ok_o   = r_ok;
    assign busy_o = (r_state != S_IDLE);
    assign done_o = (r_state == S_DONE);

endmodule
`default_nettype wire
